shifter_seq: RTL

//  Multi-cycle N-bit barrel-shift engine with selectable mode (SLL/SRL/SRA/ROL) and range-checked shift amount.

---
 rtl/shifter_pkg.sv | 17 +
 rtl/shifter_step.sv | 32 +++
 rtl/shifter_seq.sv | 109 ++++++++++
 3 files changed

// File: rtl/shifter_pkg.sv
// Shared types for the sequential barrel-shift engine.
package shifter_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROL = 2'b11
  } shift_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/shifter_step.sv
// Combinational stage: shifts an N-bit word by 0..STEP single positions in the selected mode.
module shifter_step
  import shifter_pkg::*;
#(
  parameter int N    = 8,
  parameter int STEP = 1,
  parameter int AW   = $clog2(N) + 1
) (
  input  logic [N-1:0]  word,
  input  shift_mode_t   mode,
  input  logic [AW-1:0] amt,
  output logic [N-1:0]  result
);

  function automatic logic [N-1:0] shift1(input logic [N-1:0] w, input shift_mode_t m);
    case (m)
      SH_SLL:  return {w[N-2:0], 1'b0};
      SH_SRL:  return {1'b0, w[N-1:1]};
      SH_SRA:  return {w[N-1], w[N-1:1]};
      default: return {w[N-2:0], w[N-1]};
    endcase
  endfunction

  // NOTE: combinational logic uses blocking '=' and assigns every output first, so no latch is inferred.
  always_comb begin
    result = word;
    for (int i = 0; i < STEP; i++) begin
      if (i < int'(amt)) result = shift1(result, mode);
    end
  end

endmodule

// File: rtl/shifter_seq.sv
// Multi-cycle barrel-shift engine: at most STEP positions per clock, valid/ready on both sides,
// illegal amounts reported on o_ERR with a zero result.
module shifter_seq
  import shifter_pkg::*;
#(
  parameter int N    = 8,
  parameter int STEP = 1,
  parameter int AW   = $clog2(N) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [N-1:0]  i_a,
  input  logic [AW-1:0] i_amt,
  input  shift_mode_t   i_mode,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [N-1:0]  o_out,
  output logic          o_ERR,
  output logic          o_busy
);

  localparam logic [AW-1:0] STEP_W = AW'(STEP);
  localparam logic [AW-1:0] N_W    = AW'(N);

  state_t        state;
  shift_mode_t   mode_q;
  logic [N-1:0]  work;
  logic [N-1:0]  stepped;
  logic [AW-1:0] rem;
  logic [AW-1:0] s;
  logic [AW-1:0] rem_next;
  logic [AW-1:0] mag;
  logic          amt_err;

  // Magnitude is widened by one bit so the range check stays meaningful for any N.
  assign mag      = {1'b0, i_amt[AW-2:0]};
  assign amt_err  = i_amt[AW-1] || (mag >= N_W);
  assign s        = (rem > STEP_W) ? STEP_W : rem;
  assign rem_next = rem - s;

  shifter_step #(.N(N), .STEP(STEP), .AW(AW)) u_step (
    .word   (work),
    .mode   (mode_q),
    .amt    (s),
    .result (stepped)
  );

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      mode_q  <= SH_SLL;
      work    <= '0;
      rem     <= '0;
      o_out   <= '0;
      o_ERR   <= 1'b0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
      o_ready <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            work    <= i_a;
            mode_q  <= i_mode;
            rem     <= mag;
            o_ready <= 1'b0;
            if (amt_err) begin
              state   <= ST_DONE;
              o_out   <= '0;
              o_ERR   <= 1'b1;
              o_valid <= 1'b1;
            end else if (mag == '0) begin
              state   <= ST_DONE;
              o_out   <= i_a;
              o_ERR   <= 1'b0;
              o_valid <= 1'b1;
            end else begin
              state  <= ST_BUSY;
              o_busy <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          work <= stepped;
          rem  <= rem_next;
          if (rem_next == '0) begin
            state   <= ST_DONE;
            o_busy  <= 1'b0;
            o_out   <= stepped;
            o_ERR   <= 1'b0;
            o_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (i_ready) begin
            state   <= ST_IDLE;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
